// File: rtl/rotate_pkg.sv
// rotate_pkg: shared widths, default requester count and scheduler FSM states
package rotate_pkg;
  localparam int DW       = 8;
  localparam int AW       = 3;
  localparam int NREQ_DEF = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/barrel_shifter_8.sv
// barrel_shifter_8: combinational 8-bit left/right rotator
module barrel_shifter_8 import rotate_pkg::*; (
  input  logic [DW-1:0] num,
  input  logic [AW-1:0] amt,
  input  logic          LR,
  output logic [DW-1:0] out
);
  logic [AW-1:0] w_sh;
  // a left rotate by k is a right rotate by (8-k) mod 8
  assign w_sh = LR ? AW'(0) - amt : amt;
  // each output bit picks the source bit w_sh positions above it, wrapping mod 8
  always_comb begin
    out = '0;
    for (int j = 0; j < DW; j++) out[j] = num[AW'(j) + w_sh];
  end
endmodule

// File: rtl/rotate_scheduler.sv
// rotate_scheduler: round-robin arbiter sharing one barrel rotator among NREQ requesters
module rotate_scheduler import rotate_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [DW*NREQ-1:0] req_num,
  input  logic [AW*NREQ-1:0] req_amt,
  input  logic [NREQ-1:0]    req_lr,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic [IDW-1:0]     rsp_id,
  input  logic               rsp_ready,
  output logic               busy
);
  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [DW-1:0]  r_num;
  logic [AW-1:0]  r_amt;
  logic           r_lr;
  logic [IDW-1:0] r_id;
  logic           r_rsp_valid;
  logic [DW-1:0]  r_rsp_data;
  logic [IDW-1:0] r_rsp_id;
  logic           w_grant;
  logic [IDW-1:0] w_win;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic [DW-1:0]  w_rot;
  // scan from the pointer downwards so the entry closest to rr_ptr wins last
  always_comb begin
    w_grant = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
      w_idx = (w_sum >= (IDW + 1)'(NREQ)) ? IDW'(w_sum - (IDW + 1)'(NREQ)) : IDW'(w_sum);
      if (req_valid[w_idx]) begin
        w_grant = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  assign req_ready = (r_state == IDLE && w_grant) ? NREQ'(1) << w_win : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);
  barrel_shifter_8 u_rot (
    .num (r_num),
    .amt (r_amt),
    .LR  (r_lr),
    .out (w_rot)
  );
  // accept in IDLE, rotate in EXEC, hold the response in DONE until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_num       <= '0;
      r_amt       <= '0;
      r_lr        <= 1'b0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_grant) begin
          r_state  <= EXEC;
          r_num    <= req_num[DW*w_win +: DW];
          r_amt    <= req_amt[AW*w_win +: AW];
          r_lr     <= req_lr[w_win];
          r_id     <= w_win;
          r_rr_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        end
        EXEC: begin
          r_state     <= DONE;
          r_rsp_data  <= w_rot;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        DONE: if (rsp_ready) begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rotate_scheduler.sv
// tb_rotate_scheduler: directed self-checking bench for rotate_scheduler
module tb_rotate_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_num;
  logic [11:0] req_amt;
  logic [3:0]  req_lr;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic        busy;
  int tests = 0;
  int fails = 0;

  rotate_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_num   (req_num),
    .req_amt   (req_amt),
    .req_lr    (req_lr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] n, input logic [2:0] a, input logic l);
    req_num[8*i +: 8] = n;
    req_amt[3*i +: 3] = a;
    req_lr[i]         = l;
  endtask

  // one full transaction from IDLE with rsp_ready high
  task automatic op(input string tag, input int idx, input logic [7:0] exp_data);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    chk({tag, "_ready"}, 32'(req_ready), 32'(onehot));
    step();
    chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
    chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    step();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(idx));
    step();
    chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_num = '0;
    req_amt = '0;
    req_lr = '0;
    rsp_ready = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    // single requester and rotate corners; last grant to 3 leaves rr_ptr at 0
    set_req(0, 8'h81, 3'd1, 1'b0); req_valid = 4'b0001; #1;
    chk("single_idle_busy", 32'(busy), 32'd0);
    op("single", 0, 8'hC0);
    set_req(0, 8'h81, 3'd1, 1'b1); req_valid = 4'b0001; #1;
    op("left81_1", 0, 8'h03);
    set_req(1, 8'h12, 3'd4, 1'b1); req_valid = 4'b0010; #1;
    op("left12_4", 1, 8'h21);
    set_req(2, 8'hA5, 3'd0, 1'b0); req_valid = 4'b0100; #1;
    op("rightA5_0", 2, 8'hA5);
    set_req(3, 8'h01, 3'd7, 1'b0); req_valid = 4'b1000; #1;
    op("right01_7", 3, 8'h02);
    // fairness: everyone valid, grants 0,1,2,3,0,1 back-to-back every 3 cycles
    set_req(0, 8'h01, 3'd1, 1'b1);
    set_req(1, 8'h80, 3'd1, 1'b0);
    set_req(2, 8'h0F, 3'd4, 1'b1);
    set_req(3, 8'h3C, 3'd2, 1'b0);
    req_valid = 4'b1111; #1;
    op("fair0", 0, 8'h02);
    op("fair1", 1, 8'h40);
    op("fair2", 2, 8'hF0);
    op("fair3", 3, 8'h0F);
    op("fair4", 0, 8'h02);
    op("fair5", 1, 8'h40);
    // pointer wrap: grant 3, then only 1 and 2 valid
    req_valid = 4'b1000; #1;
    op("wrap3", 3, 8'h0F);
    req_valid = 4'b0110; #1;
    op("wrap1", 1, 8'h40);
    op("wrap2", 2, 8'hF0);
    // backpressure: rr_ptr is 3, only requester 0 valid
    req_valid = 4'b0001; rsp_ready = 1'b0; #1;
    chk("bp_ready", 32'(req_ready), 32'b0001);
    step();
    step();
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(rsp_data), 32'h02);
      chk("bp_hold_id", 32'(rsp_id), 32'd0);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1; #1;
    chk("bp_same_cycle_ready", 32'(req_ready), 32'd0);
    step();
    chk("bp_released_valid", 32'(rsp_valid), 32'd0);
    chk("bp_next_winner", 32'(req_ready), 32'b0010);
    // reset during EXEC: rr_ptr is 1, requester 1 starts and is discarded
    req_valid = 4'b0010; #1;
    chk("rmid_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    chk("rmid_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_valid", 32'(rsp_valid), 32'd0);
    chk("rmid_data", 32'(rsp_data), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rmid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b0101; #1;
    op("rmid_ptr0", 0, 8'h02);
    req_valid = '0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rotate_scheduler.md
# rotate_scheduler

Round-robin scheduler that shares one 8-bit left/right barrel rotator among `NREQ` requesters. Each requester presents an operand, rotate amount and direction under a valid/ready handshake. The scheduler grants one request at a time, registers the operands, runs them through the shared rotator, and returns the registered result tagged with the requester ID under a valid/ready response handshake. It sits between the client blocks and the single rotator instance, so the client blocks never drive the rotator directly.

## Interface
- `NREQ`, 4: number of requesters; range 2..8.
- `IDW`, 2: width of the requester ID; equals ceil(log2(NREQ)).

- `clk`  in  1: single clock; all flops rising-edge.
- `rst_n`  in  1: asynchronous active-low reset; release is synchronous to `clk` externally.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_num`  in  8*NREQ: operand; requester i uses bits [8i+7:8i].
- `req_amt`  in  3*NREQ: rotate amount 0..7; requester i uses bits [3i+2:3i].
- `req_lr`  in  NREQ: direction per requester; 1 = rotate left, 0 = rotate right.
- `req_ready`  out  NREQ: grant/accept strobe; at most one bit high at a time.
- `rsp_valid`  out  1: result available.
- `rsp_data`  out  8: rotated result.
- `rsp_id`  out  IDW: index of the requester that owns `rsp_data`.
- `rsp_ready`  in  1: consumer accepts the result.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid` is high, pick the winner and go to EXEC; otherwise stay in IDLE.
  - EXEC: go to DONE unconditionally.
  - DONE: go to IDLE when `rsp_valid && rsp_ready`; otherwise stay in DONE.
- Accept rules:
  - `req_ready` is combinational and high only in IDLE.
  - It is one-hot, on the round-robin winner among the set `req_valid` bits.
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
- On transfer, register `num`, `amt`, `lr` and the winner index into the operand registers.
- Round-robin:
  - The pointer `rr_ptr` holds the index with highest priority.
  - The search order is `rr_ptr`, `rr_ptr+1`, …, wrapping modulo NREQ.
  - After a grant to index g, `rr_ptr` becomes (g+1) mod NREQ.
  - `rr_ptr` is unchanged when there is no grant.
  - With NREQ not a power of two, the wrap from NREQ-1 goes to 0 and never reaches an unused index.
- In EXEC, the combinational rotator output from the operand registers is captured into `rsp_data`. `rsp_id` takes the latched index.
- Rotate semantics:
  - Right by k: out[j] = num[(j+k) mod 8].
  - Left by k: out[j] = num[(j-k) mod 8].
  - k = 0 passes the operand through unchanged.
- In DONE:
  - `rsp_valid` is high and `rsp_data`/`rsp_id` are held stable until accepted.
  - Requests are not accepted in DONE, even on the same cycle the response is accepted.
- Requesters must hold `req_valid`, `req_num`, `req_amt` and `req_lr` stable until granted. A requester dropping `req_valid` before its grant is legal and simply leaves it out of arbitration.

## Timing
- Reset values: state = IDLE, `rr_ptr` = 0, `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0x00, `rsp_id` = 0, `busy` = 0, operand registers all 0.
- Latency: accept in cycle t → `rsp_valid` high in cycle t+2.
- Throughput: with `rsp_ready` held high, one operation per 3 cycles (accept in t, response accepted in t+2, next accept in t+3).
- Backpressure: while `rsp_ready` is low, the FSM stays in DONE indefinitely and all `req_ready` bits stay low.
- Reset asserted mid-operation (EXEC or DONE):
  - All outputs go to their reset values immediately.
  - The in-flight result is discarded with no response.
  - The requester is not re-served automatically; it must re-request.
- Simultaneous requests from all requesters: served strictly in rotation, with no requester starved. Worst-case wait is NREQ-1 operations.

## Structure
- Shared package `rotate_pkg`:
  - Constants `DW = 8` and `AW = 3`.
  - The FSM state enum with IDLE, EXEC and DONE encoded as 2'd0, 2'd1 and 2'd2.
  - The default NREQ.
- One sub-module: the existing `barrel_shifter_8`.
  - Instantiated once, combinational, driven from the operand registers.
  - Port mapping: `num` from the operand, `amt` from the amount, `LR` from `lr`.
- The round-robin winner search is an in-module combinational loop. It does not become a separate module.

## Test plan
- Single requester, reset released: requester 0 sends `num`=0x81, `amt`=1, `lr`=0 → `req_ready[0]` high the same cycle; `rsp_valid` two cycles later with `rsp_data`=0xC0, `rsp_id`=0.
- Direction and amount corners:
  - Left 0x81 by 1 → 0x03.
  - Left 0x12 by 4 → 0x21.
  - Right 0xA5 by 0 → 0xA5.
  - Right 0x01 by 7 → 0x02.
- Fairness: all four requesters valid continuously with `rsp_ready` high → grants in order 0,1,2,3,0,1; accepts exactly 3 cycles apart; each `rsp_id` matches the grant.
- Pointer wrap: after a grant to 3, only requesters 1 and 2 valid → requester 1 granted next, then 2.
- Backpressure: `rsp_ready` low for 10 cycles in DONE → `rsp_valid`, `rsp_data` and `rsp_id` stable; `req_ready` all 0 while other requests pend; accept completes the cycle `rsp_ready` rises.
- Reset mid-operation: assert `rst_n` low in the EXEC cycle → `rsp_valid` is never raised for that request; after release, `rr_ptr` is 0, so with requesters 2 and 0 valid, requester 0 wins.
